// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor with IDLE/SHIFT/DONE control, one bit per cycle.
// Optional unsigned saturation on underflow: define SERIAL_SUB_CLAMP_EN.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             bin;

  logic             ai;
  logic             bi;
  logic             x;
  logic             b1;
  logic             b2;
  logic             d;
  logic             bout;
  logic             last;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] diff_nx;

  assign ai   = a_sh[0];
  assign bi   = b_sh[0];
  assign x    = ai ^ bi;
  assign b1   = ~ai & bi;
  assign d    = x ^ bin;
  assign b2   = ~x & bin;
  assign bout = b1 | b2;

  assign last = (cnt == CW'(WIDTH - 1));
  assign r_nx = {d, r_sh[WIDTH-1:1]};

`ifdef SERIAL_SUB_CLAMP_EN
  assign diff_nx = bout ? '0 : r_nx;
`else
  assign diff_nx = r_nx;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath: operands shift right, result fills from the MSB side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            r_sh <= '0;
            cnt  <= '0;
            bin  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nx;
          bin  <= bout;
          if (last) begin
            cnt    <= '0;
            diff   <= diff_nx;
            borrow <= bout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl at WIDTH=8.
// Expected results queued at drive time, popped when done rises.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int pass_cnt;
  int tot_cnt;
  logic [W:0] sb[$];

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tot_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    logic [W-1:0] dd;
    logic         bb;
    bb = (x < y);
    dd = x - y;
`ifdef SERIAL_SUB_CLAMP_EN
    if (bb) dd = '0;
`endif
    return {bb, dd};
  endfunction

  always @(negedge clk) begin
    logic [W:0] e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e[W-1:0]});
        check("borrow", {31'd0, borrow}, {31'd0, e[W]});
      end
    end
  end

  // Counts SHIFT cycles from just after the accepting edge.
  task automatic wait_done(input string tag, input logic [W-1:0] d0);
    int nb;
    bit stable;
    nb = 0;
    stable = 1'b1;
    while (busy && nb < 50) begin
      if (diff !== d0 || ready) stable = 1'b0;
      @(posedge clk); #1;
      nb++;
    end
    check({tag, "_busy_cycles"}, nb, W);
    check({tag, "_hold"}, {31'd0, stable}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic [W-1:0] d0;
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    sb.push_back(model(ta, tb_v));
    d0 = diff;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_done("op", d0);
    @(posedge clk); #1;
    check("pulse_end", {31'd0, done}, 32'd0);
    check("ready_back", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] d0;
    pass_cnt = 0;
    tot_cnt  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #3;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    run_op(8'h35, 8'h12);
    run_op(8'h12, 8'h35);
    run_op(8'hFF, 8'hFF);
    run_op(8'h00, 8'h01);
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom));
    end

    // start held high across SHIFT and DONE
    @(negedge clk);
    a = 8'h80;
    b = 8'h01;
    start = 1'b1;
    sb.push_back(model(8'h80, 8'h01));
    d0 = diff;
    @(posedge clk); #1;
    a = 8'h33;
    b = 8'h11;
    wait_done("hold1", d0);
    check("hold_no_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    check("hold_idle", {31'd0, ready}, 32'd1);
    check("hold_pulse_end", {31'd0, done}, 32'd0);
    sb.push_back(model(8'h33, 8'h11));
    d0 = diff;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_accept2", {31'd0, busy}, 32'd1);
    wait_done("hold2", d0);
    @(posedge clk); #1;

    // reset in the middle of SHIFT
    @(negedge clk);
    a = 8'h40;
    b = 8'h20;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_ready", {31'd0, ready}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_diff", {24'd0, diff}, 32'd0);
    check("mid_borrow", {31'd0, borrow}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_op(8'h0A, 8'h03);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
